// File: rtl/seq_sdivmod_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives the request; the slave (the divider) returns status and results.
interface seq_sdivmod_if #(parameter int DATAWIDTH = 64);
  logic                 start;
  logic [DATAWIDTH-1:0] dividend;
  logic [DATAWIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] quot;
  logic [DATAWIDTH-1:0] rem;
  logic                 divz;

  modport master (output start, dividend, divisor,
                  input  busy, done, quot, rem, divz);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quot, rem, divz);
endinterface

// File: rtl/seq_sdivmod.sv
// Sequential signed divide/modulo, restoring radix-2, one quotient bit per cycle.
// Results follow Verilog signed / and %; divide by zero gives quot=-1, rem=dividend.
// Optional macro SEQ_SDIVMOD_DIVZ_FAST_EN: a zero-divisor request skips RUN and
// completes one cycle after it is accepted.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accepted start
// RUN   | DATAWIDTH shift/subtract steps on the magnitudes
// FIX   | apply signs, register results, pulse done
module seq_sdivmod #(
  parameter int DATAWIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  seq_sdivmod_if.slave bus
);
  localparam int W  = DATAWIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W:0]    pr_q;        // partial remainder magnitude
  logic [W:0]    qm_q;        // dividend bits shifting out, quotient bits shifting in
  logic [W:0]    dvs_mag_q;
  logic [W-1:0]  dvd_q;
  logic          sgn_a_q, sgn_b_q, dvs_zero_q;

  logic [W:0]    dvd_ext, dvs_ext, dvd_mag, dvs_mag;
  logic [W:0]    sh, diff, q_signed, r_signed;
  logic          take, last_step, in_dvs_zero;
  logic          unused_bits;

  // Magnitudes are one bit wider than the operands so the most-negative value negates cleanly.
  assign dvd_ext     = {bus.dividend[W-1], bus.dividend};
  assign dvs_ext     = {bus.divisor[W-1], bus.divisor};
  assign dvd_mag     = bus.dividend[W-1] ? -dvd_ext : dvd_ext;
  assign dvs_mag     = bus.divisor[W-1] ? -dvs_ext : dvs_ext;
  assign in_dvs_zero = (bus.divisor == '0);

  assign sh        = {pr_q[W-1:0], qm_q[W-1]};
  assign diff      = sh - dvs_mag_q;
  assign take      = (sh >= dvs_mag_q);
  assign last_step = (cnt_q == CW'(W - 1));

  // Only the low W bits of the signed magnitudes are meaningful; the wrap gives min/-1 = min.
  assign q_signed    = (sgn_a_q ^ sgn_b_q) ? -qm_q : qm_q;
  assign r_signed    = sgn_a_q ? -pr_q : pr_q;
  assign unused_bits = ^{q_signed[W], r_signed[W]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef SEQ_SDIVMOD_DIVZ_FAST_EN
          state_d = in_dvs_zero ? FIX : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (last_step) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and the restoring shift/subtract datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pr_q       <= '0;
      qm_q       <= '0;
      dvs_mag_q  <= '0;
      dvd_q      <= '0;
      sgn_a_q    <= 1'b0;
      sgn_b_q    <= 1'b0;
      dvs_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q      <= '0;
            pr_q       <= '0;
            qm_q       <= dvd_mag;
            dvs_mag_q  <= dvs_mag;
            dvd_q      <= bus.dividend;
            sgn_a_q    <= bus.dividend[W-1];
            sgn_b_q    <= bus.divisor[W-1];
            dvs_zero_q <= in_dvs_zero;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          pr_q  <= take ? diff : sh;
          qm_q  <= {qm_q[W-1:0], take};
        end
        default: ;
      endcase
    end
  end

  // Status and result registers; results only change in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quot <= '0;
      bus.rem  <= '0;
      bus.divz <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_q == FIX);
      if (state_q == FIX) begin
        bus.divz <= dvs_zero_q;
        if (dvs_zero_q) begin
          bus.quot <= '1;
          bus.rem  <= dvd_q;
        end else begin
          bus.quot <= q_signed[W-1:0];
          bus.rem  <= r_signed[W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_sdivmod.sv
// Directed and randomized checks of seq_sdivmod at DATAWIDTH 64 and 8.
module tb_seq_sdivmod;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam int LAT64 = 65;
  localparam int LAT8  = 9;
`ifdef SEQ_SDIVMOD_DIVZ_FAST_EN
  localparam int DZ64 = 1;
  localparam int DZ8  = 1;
`else
  localparam int DZ64 = 65;
  localparam int DZ8  = 9;
`endif

  seq_sdivmod_if #(.DATAWIDTH(64)) b64 ();
  seq_sdivmod_if #(.DATAWIDTH(8))  b8 ();

  seq_sdivmod #(.DATAWIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));
  seq_sdivmod #(.DATAWIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic op64(input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] q, output logic [63:0] r,
                      output logic z, output int lat);
    @(negedge clk);
    b64.dividend = a; b64.divisor = b; b64.start = 1'b1;
    @(posedge clk); #1;
    b64.start = 1'b0; b64.dividend = ~a; b64.divisor = 64'd0;
    lat = 0;
    while (b64.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    q = b64.quot; r = b64.rem; z = b64.divz;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r,
                     output logic z, output int lat);
    @(negedge clk);
    b8.dividend = a; b8.divisor = b; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.dividend = ~a; b8.divisor = 8'd0;
    lat = 0;
    while (b8.done !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    q = b8.quot; r = b8.rem; z = b8.divz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b64.busy, b64.done, b64.divz, b64.quot, b64.rem} !== 131'd0) begin
      errors++;
      $display("FAIL reset64 got busy=%b done=%b divz=%b quot=%h rem=%h exp all zero",
               b64.busy, b64.done, b64.divz, b64.quot, b64.rem);
    end
    checks++;
    if ({b8.busy, b8.done, b8.divz, b8.quot, b8.rem} !== 19'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b divz=%b quot=%h rem=%h exp all zero",
               b8.busy, b8.done, b8.divz, b8.quot, b8.rem);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_signs();
    longint va[4] = '{7, -7, 7, -7};
    longint vb[4] = '{2, 2, -2, -2};
    longint eq[4] = '{3, -3, -3, 3};
    longint er[4] = '{1, -1, 1, -1};
    logic [63:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 4; i++) begin
      op64(64'(va[i]), 64'(vb[i]), q, r, z, lat);
      checks++;
      if (q !== 64'(eq[i])) begin
        errors++; $display("FAIL signs_quot[%0d] got=%0d exp=%0d", i, $signed(q), eq[i]);
      end
      checks++;
      if (r !== 64'(er[i]) || z !== 1'b0) begin
        errors++; $display("FAIL signs_rem[%0d] got=%0d divz=%b exp=%0d divz=0", i, $signed(r), z, er[i]);
      end
      checks++;
      if (lat != LAT64) begin
        errors++; $display("FAIL signs_latency[%0d] got=%0d exp=%0d", i, lat, LAT64);
      end
    end
  endtask

  task automatic test_most_negative();
    logic [7:0] q, r;
    logic z;
    int lat;
    op8(8'h80, 8'hff, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'h80, 8'h00, 1'b0}) begin
      errors++; $display("FAIL minneg_div_m1 got q=%h r=%h divz=%b exp q=80 r=00 divz=0", q, r, z);
    end
    checks++;
    if (lat != LAT8) begin
      errors++; $display("FAIL minneg_latency got=%0d exp=%0d", lat, LAT8);
    end
    op8(8'h80, 8'h01, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'h80, 8'h00, 1'b0}) begin
      errors++; $display("FAIL minneg_div_p1 got q=%h r=%h divz=%b exp q=80 r=00 divz=0", q, r, z);
    end
  endtask

  task automatic test_divz();
    logic [63:0] q, r;
    logic [7:0] q8, r8;
    logic z;
    int lat;
    op64(64'd5, 64'd0, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {64'hffff_ffff_ffff_ffff, 64'd5, 1'b1}) begin
      errors++; $display("FAIL divz64 got q=%h r=%h divz=%b exp q=all-ones r=5 divz=1", q, r, z);
    end
    checks++;
    if (lat != DZ64) begin
      errors++; $display("FAIL divz64_latency got=%0d exp=%0d", lat, DZ64);
    end
    op8(8'h9c, 8'h00, q8, r8, z, lat);
    checks++;
    if ({q8, r8, z} !== {8'hff, 8'h9c, 1'b1}) begin
      errors++; $display("FAIL divz8 got q=%h r=%h divz=%b exp q=ff r=9c divz=1", q8, r8, z);
    end
    checks++;
    if (lat != DZ8) begin
      errors++; $display("FAIL divz8_latency got=%0d exp=%0d", lat, DZ8);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q, r;
    logic z;
    int lat;
    int ndone;
    @(negedge clk);
    b64.dividend = 64'd100; b64.divisor = 64'd7; b64.start = 1'b1;
    @(posedge clk); #1;
    b64.start = 1'b0;
    lat = 0; ndone = 0;
    while (b64.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (lat == 5) begin b64.dividend = 64'd9; b64.divisor = 64'd3; b64.start = 1'b1; end
      if (lat == 6) b64.start = 1'b0;
    end
    checks++;
    if ({b64.quot, b64.rem} !== {64'd14, 64'd2} || lat != LAT64) begin
      errors++; $display("FAIL ignore_start got q=%0d r=%0d lat=%0d exp q=14 r=2 lat=%0d",
                         b64.quot, b64.rem, lat, LAT64);
    end
    op64(64'd9, 64'd3, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {64'd3, 64'd0, 1'b0} || lat != LAT64) begin
      errors++; $display("FAIL back_to_back got q=%0d r=%0d divz=%b lat=%0d exp q=3 r=0 divz=0 lat=%0d",
                         q, r, z, lat, LAT64);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] q, r;
    logic z;
    int lat;
    bit seen;
    @(negedge clk);
    b64.dividend = 64'd100; b64.divisor = 64'd7; b64.start = 1'b1;
    @(posedge clk); #1;
    b64.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (b64.busy !== 1'b1) begin
      errors++; $display("FAIL busy_in_run got=%b exp=1", b64.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({b64.busy, b64.done, b64.divz, b64.quot, b64.rem} !== 131'd0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b divz=%b quot=%h rem=%h exp all zero",
                         b64.busy, b64.done, b64.divz, b64.quot, b64.rem);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (b64.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL aborted_done got=%b exp=0", seen);
    end
    op64(64'd20, -64'sd6, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {-64'sd3, 64'd2, 1'b0}) begin
      errors++; $display("FAIL after_reset got q=%0d r=%0d divz=%b exp q=-3 r=2 divz=0", $signed(q), $signed(r), z);
    end
  endtask

  task automatic test_hold();
    logic [7:0] q, r;
    logic z;
    int lat;
    op8(8'd100, 8'd7, q, r, z, lat);
    checks++;
    if ({q, r} !== {8'd14, 8'd2}) begin
      errors++; $display("FAIL hold_op got q=%0d r=%0d exp q=14 r=2", q, r);
    end
    @(posedge clk); #1;
    checks++;
    if (b8.done !== 1'b0) begin
      errors++; $display("FAIL done_pulse got=%b exp=0", b8.done);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({b8.quot, b8.rem, b8.divz, b8.busy} !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL hold got q=%0d r=%0d divz=%b busy=%b exp q=14 r=2 divz=0 busy=0",
                         b8.quot, b8.rem, b8.divz, b8.busy);
    end
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hff;
      3: return 8'h80;
      4: return 8'h7f;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'hffff_ffff_ffff_ffff;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7fff_ffff_ffff_ffff;
      5: return 64'($urandom_range(0, 200)) - 64'd100;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic test_random8(input int n);
    logic [7:0] a, b, q, r, eq, er;
    logic z, ez;
    int ai, bi, lat;
    for (int i = 0; i < n; i++) begin
      a = pick8(); b = pick8();
      ai = $signed(a); bi = $signed(b);
      if (bi == 0) begin eq = 8'hff; er = a; ez = 1'b1; end
      else begin eq = 8'(ai / bi); er = 8'(ai % bi); ez = 1'b0; end
      op8(a, b, q, r, z, lat);
      checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
        errors++; $display("FAIL random8 a=%h b=%h got q=%h r=%h divz=%b exp q=%h r=%h divz=%b",
                           a, b, q, r, z, eq, er, ez);
      end
    end
  endtask

  task automatic test_random64(input int n);
    logic [63:0] a, b, q, r, eq, er;
    logic z, ez;
    longint ai, bi;
    int lat;
    for (int i = 0; i < n; i++) begin
      a = pick64(); b = pick64();
      ai = $signed(a); bi = $signed(b);
      if (bi == 0) begin eq = '1; er = a; ez = 1'b1; end
      else if (a == 64'h8000_0000_0000_0000 && bi == -1) begin eq = a; er = '0; ez = 1'b0; end
      else begin eq = 64'(ai / bi); er = 64'(ai % bi); ez = 1'b0; end
      op64(a, b, q, r, z, lat);
      checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
        errors++; $display("FAIL random64 a=%h b=%h got q=%h r=%h divz=%b exp q=%h r=%h divz=%b",
                           a, b, q, r, z, eq, er, ez);
      end
    end
  endtask

  initial begin
    b64.start = 1'b0; b64.dividend = '0; b64.divisor = '0;
    b8.start  = 1'b0; b8.dividend  = '0; b8.divisor  = '0;
    test_reset();
    test_signs();
    test_most_negative();
    test_divz();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_random8(2000);
    test_random64(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
